// File: rtl/rom_dl_pkg.sv
// Shared types for the ROM download packer: controller states, the FIFO word
// layout and the default fill byte for an unpaired half-word.
package rom_dl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } dl_state_e;

    localparam logic [7:0] PAD_BYTE_DEF = 8'hFF;

    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] data;
    } word_t;

    localparam word_t WORD_ZERO = '{addr: 24'd0, data: 16'd0};

    // Big-endian packing: the even byte lands in the upper half.
    function automatic word_t make_word(input logic [23:0] addr,
                                        input logic [7:0]  hi,
                                        input logic [7:0]  lo);
        word_t w;
        w.addr = addr;
        w.data = {hi, lo};
        return w;
    endfunction

endpackage

// File: rtl/word_fifo.sv
// Synchronous word FIFO; full/empty told apart by one extra pointer bit.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module word_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 40
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);
    localparam logic [AW:0] PTR_ZERO = (AW + 1)'(0);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop_s  = pop_i & ~empty_o;
    assign do_push_s = push_i & (~full_o | do_pop_s);
    assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; both wrap naturally through the extra MSB.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
        end else begin
            wr_ptr_q <= do_push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
            rd_ptr_q <= do_pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        end
    end

    // Storage write; contents are don't-care until a pointer covers them.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/rom_dl_packer.sv
// Packs the byte stream of a ROM download into big-endian 16-bit words and
// queues them as SDRAM write requests, reporting completion and lost words.
module rom_dl_packer
    import rom_dl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  PAD_BYTE   = PAD_BYTE_DEF
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        rom_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        sdr_req,
    input  logic        sdr_ack,
    output logic [23:0] sdr_addr,
    output logic [15:0] sdr_data,
    output logic        rom_loaded,
    output logic        overflow
);
    dl_state_e   state_q;
    logic        dl_q;
    logic        pend_vld_q, pend_vld_d;
    logic [23:0] pend_addr_q, pend_addr_d;
    logic [7:0]  pend_byte_q, pend_byte_d;
    logic        skid_vld_q, skid_vld_d;
    word_t       skid_q, skid_d;
    logic        rom_loaded_q;
    logic        overflow_q;

    logic        dl_rise_s, dl_fall_s, wr_en_s;
    logic        w0_vld_s, w1_vld_s;
    word_t       w0_s, w1_s;
    logic        push_s, pop_s, extra_drop_s, drop_s, drained_s;
    word_t       push_word_s, head_s;
    logic        fifo_full_s, fifo_empty_s;

    assign dl_rise_s = rom_download & ~dl_q;
    assign dl_fall_s = ~rom_download & dl_q;
    // A write arriving in the rise cycle already belongs to the new download.
    assign wr_en_s   = ioctl_wr & rom_download & ((state_q == ST_LOAD) | dl_rise_s);

    // Pair bytes into up to two words per cycle and update the pending even byte.
    always_comb begin
        w0_vld_s    = 1'b0;
        w1_vld_s    = 1'b0;
        w0_s        = make_word(pend_addr_q, pend_byte_q, PAD_BYTE);
        w1_s        = make_word(ioctl_addr[24:1], PAD_BYTE, ioctl_dout);
        pend_vld_d  = pend_vld_q;
        pend_addr_d = pend_addr_q;
        pend_byte_d = pend_byte_q;
        if (wr_en_s) begin
            if (!ioctl_addr[0]) begin
                w0_vld_s    = pend_vld_q;
                pend_vld_d  = 1'b1;
                pend_addr_d = ioctl_addr[24:1];
                pend_byte_d = ioctl_dout;
            end else if (pend_vld_q && (pend_addr_q == ioctl_addr[24:1])) begin
                w0_vld_s   = 1'b1;
                w0_s       = make_word(pend_addr_q, pend_byte_q, ioctl_dout);
                pend_vld_d = 1'b0;
            end else if (pend_vld_q) begin
                w0_vld_s   = 1'b1;
                w1_vld_s   = 1'b1;
                pend_vld_d = 1'b0;
            end else begin
                w0_vld_s   = 1'b1;
                w0_s       = w1_s;
                pend_vld_d = 1'b0;
            end
        end else if (dl_fall_s && pend_vld_q) begin
            w0_vld_s   = 1'b1;
            pend_vld_d = 1'b0;
        end else begin
            w0_vld_s   = 1'b0;
        end
    end

    // One FIFO push per cycle; the oldest candidate goes first, the next waits in the skid.
    always_comb begin
        push_s       = 1'b0;
        push_word_s  = skid_q;
        skid_vld_d   = 1'b0;
        skid_d       = skid_q;
        extra_drop_s = 1'b0;
        if (skid_vld_q) begin
            push_s       = 1'b1;
            skid_vld_d   = w0_vld_s;
            skid_d       = w0_s;
            extra_drop_s = w1_vld_s;
        end else if (w0_vld_s) begin
            push_s      = 1'b1;
            push_word_s = w0_s;
            skid_vld_d  = w1_vld_s;
            skid_d      = w1_s;
        end else begin
            push_s      = 1'b0;
        end
    end

    assign pop_s     = sdr_ack & ~fifo_empty_s;
    assign drop_s    = extra_drop_s | (push_s & fifo_full_s & ~pop_s);
    assign drained_s = fifo_empty_s & ~skid_vld_q & ~pend_vld_q;

    word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(word_t))
    ) u_fifo (
        .clk_i   (clk_sys),
        .rst_n_i (reset_n),
        .push_i  (push_s),
        .wdata_i (push_word_s),
        .pop_i   (pop_s),
        .rdata_o (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Pairing and skid registers; dl_q resets high so a level held across reset is not a rise.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dl_q        <= 1'b1;
            pend_vld_q  <= 1'b0;
            pend_addr_q <= 24'd0;
            pend_byte_q <= 8'd0;
            skid_vld_q  <= 1'b0;
            skid_q      <= WORD_ZERO;
        end else begin
            dl_q        <= rom_download;
            pend_vld_q  <= pend_vld_d;
            pend_addr_q <= pend_addr_d;
            pend_byte_q <= pend_byte_d;
            skid_vld_q  <= skid_vld_d;
            skid_q      <= skid_d;
        end
    end

    // Download controller with its sticky status flags.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            rom_loaded_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            if (dl_rise_s) begin
                overflow_q <= 1'b0;
            end else if (drop_s) begin
                overflow_q <= 1'b1;
            end else begin
                overflow_q <= overflow_q;
            end
            case (state_q)
                ST_IDLE: begin
                    state_q      <= dl_rise_s ? ST_LOAD : ST_IDLE;
                    rom_loaded_q <= 1'b0;
                end
                ST_LOAD: begin
                    state_q      <= dl_fall_s ? ST_DRAIN : ST_LOAD;
                    rom_loaded_q <= 1'b0;
                end
                ST_DRAIN: begin
                    if (dl_rise_s) begin
                        state_q      <= ST_LOAD;
                        rom_loaded_q <= 1'b0;
                    end else if (drained_s) begin
                        state_q      <= ST_DONE;
                        rom_loaded_q <= 1'b1;
                    end else begin
                        state_q      <= ST_DRAIN;
                        rom_loaded_q <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_q      <= dl_rise_s ? ST_LOAD : ST_DONE;
                    rom_loaded_q <= ~dl_rise_s;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    rom_loaded_q <= 1'b0;
                end
            endcase
        end
    end

    assign sdr_req    = ~fifo_empty_s;
    assign sdr_addr   = fifo_empty_s ? 24'd0 : head_s.addr;
    assign sdr_data   = fifo_empty_s ? 16'd0 : head_s.data;
    assign rom_loaded = rom_loaded_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_rom_dl_packer.sv
// Randomised and directed bench for rom_dl_packer: a byte-pairing reference
// model fills an expected-write queue that a monitor drains on each SDRAM ack.
module tb_rom_dl_packer;
    localparam logic [7:0] PAD = 8'hFF;
    localparam int DEPTH = 4;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        rom_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        sdr_req;
    logic        sdr_ack;
    logic [23:0] sdr_addr;
    logic [15:0] sdr_data;
    logic        rom_loaded;
    logic        overflow;

    int n_vec = 0;
    int n_err = 0;

    logic [39:0] exp_q[$];
    int          keep_limit = -1;
    int          kept = 0;
    logic        pm_vld = 1'b0;
    logic [23:0] pm_addr = 24'd0;
    logic [7:0]  pm_byte = 8'd0;
    logic        ack_en = 1'b0;
    logic        rand_dly = 1'b0;

    rom_dl_packer #(.FIFO_DEPTH(DEPTH), .PAD_BYTE(PAD)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .rom_download (rom_download),
        .ioctl_wr     (ioctl_wr),
        .ioctl_addr   (ioctl_addr),
        .ioctl_dout   (ioctl_dout),
        .sdr_req      (sdr_req),
        .sdr_ack      (sdr_ack),
        .sdr_addr     (sdr_addr),
        .sdr_data     (sdr_data),
        .rom_loaded   (rom_loaded),
        .overflow     (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    // Expected SDRAM write; while keep_limit is set, only that many survive a stalled FIFO.
    task automatic exp_push(input logic [23:0] wa, input logic [7:0] hi, input logic [7:0] lo);
        if (keep_limit < 0 || kept < keep_limit) exp_q.push_back({wa, hi, lo});
        kept++;
    endtask

    // Reference: a word is written once both halves are known or its partner can no longer arrive.
    task automatic model_byte(input logic [24:0] a, input logic [7:0] d);
        if (!a[0]) begin
            if (pm_vld) exp_push(pm_addr, pm_byte, PAD);
            pm_vld = 1'b1;
            pm_addr = a[24:1];
            pm_byte = d;
        end else if (pm_vld && pm_addr == a[24:1]) begin
            exp_push(pm_addr, pm_byte, d);
            pm_vld = 1'b0;
        end else begin
            if (pm_vld) exp_push(pm_addr, pm_byte, PAD);
            exp_push(a[24:1], PAD, d);
            pm_vld = 1'b0;
        end
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        model_byte(a, d);
        ioctl_wr = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        tick(1);
        ioctl_wr = 1'b0;
    endtask

    task automatic start_dl();
        rom_download = 1'b1;
        pm_vld = 1'b0;
        tick(1);
    endtask

    task automatic end_dl();
        if (pm_vld) exp_push(pm_addr, pm_byte, PAD);
        pm_vld = 1'b0;
        rom_download = 1'b0;
        tick(1);
    endtask

    task automatic wait_done(input string nm);
        int c = 0;
        while (!(rom_loaded === 1'b1 && exp_q.size() == 0) && c < 400) begin
            tick(1);
            c++;
        end
        chk({nm, " rom_loaded"}, 40'(rom_loaded), 40'd1);
        chk({nm, " writes left"}, 40'(exp_q.size()), 40'd0);
    endtask

    // SDRAM side: acknowledge a held request after a fixed or random delay, with stray acks.
    initial begin : responder
        int wc;
        wc = -1;
        sdr_ack = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            sdr_ack = 1'b0;
            if (!ack_en || !reset_n) begin
                wc = -1;
            end else if (sdr_req) begin
                if (wc < 0) wc = rand_dly ? int'($urandom_range(0, 3)) : 2;
                if (wc == 0) begin
                    sdr_ack = 1'b1;
                    wc = -1;
                end else begin
                    wc--;
                end
            end else if (rand_dly && $urandom_range(0, 7) == 0) begin
                sdr_ack = 1'b1;
            end
        end
    end

    // Monitor: compare each accepted write and check the head stays put while waiting.
    initial begin : monitor
        logic        hold_prev;
        logic [39:0] prev_word;
        logic [39:0] e;
        hold_prev = 1'b0;
        prev_word = 40'd0;
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    chk("req held", 40'(sdr_req), 40'd1);
                    chk("head stable", {sdr_addr, sdr_data}, prev_word);
                end
                if (sdr_req && sdr_ack) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected write: got %h expected none", {sdr_addr, sdr_data});
                    end else begin
                        e = exp_q.pop_front();
                        chk("write", {sdr_addr, sdr_data}, e);
                    end
                end
                hold_prev = sdr_req && !sdr_ack;
                prev_word = {sdr_addr, sdr_data};
            end
        end
    end

    initial begin : stimulus
        logic [24:0] cur;
        reset_n = 1'b0;
        rom_download = 1'b0;
        ioctl_wr = 1'b0;
        ioctl_addr = 25'd0;
        ioctl_dout = 8'd0;
        #2;
        chk("reset outputs", {sdr_req, sdr_addr, sdr_data[14:0]}, 40'd0);
        chk("reset flags", {38'd0, rom_loaded, overflow}, 40'd0);
        tick(3);
        reset_n = 1'b1;
        tick(2);

        // Simple pair, ack two cycles after request.
        ack_en = 1'b1;
        start_dl();
        wr_byte(25'd0, 8'h12);
        wr_byte(25'd1, 8'h34);
        chk("push latency req", 40'(sdr_req), 40'd1);
        chk("push latency head", {sdr_addr, sdr_data}, {24'd0, 16'h1234});
        tick(3);
        chk("loaded during load", 40'(rom_loaded), 40'd0);
        end_dl();
        wait_done("pair");

        // Lone odd byte, then flush of a lone even byte followed by another even.
        start_dl();
        chk("loaded cleared", 40'(rom_loaded), 40'd0);
        wr_byte(25'd5, 8'hAB);
        end_dl();
        wait_done("lone odd");
        start_dl();
        wr_byte(25'd0, 8'h11);
        tick(2);
        wr_byte(25'd2, 8'h22);
        tick(2);
        end_dl();
        wait_done("even only");

        // Stalled SDRAM: only the first FIFO_DEPTH words survive.
        ack_en = 1'b0;
        start_dl();
        kept = 0;
        keep_limit = DEPTH;
        for (int i = 0; i < 12; i++) begin
            wr_byte(25'(2 * i), 8'(i + 8'h40));
            wr_byte(25'(2 * i + 1), 8'(i + 8'h80));
        end
        end_dl();
        tick(5);
        chk("overflow set", 40'(overflow), 40'd1);
        chk("loaded while full", 40'(rom_loaded), 40'd0);
        chk("full head", {sdr_addr, sdr_data}, {24'd0, 16'h4080});
        keep_limit = -1;
        ack_en = 1'b1;
        wait_done("overflow drain");
        chk("overflow sticky", 40'(overflow), 40'd1);

        // New download clears the sticky flags; random traffic follows.
        start_dl();
        chk("overflow cleared", 40'(overflow), 40'd0);
        chk("loaded cleared 2", 40'(rom_loaded), 40'd0);
        rand_dly = 1'b1;
        cur = 25'h100;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: cur = cur + 25'd1;
                6, 7:             cur = cur + 25'd2;
                default:          cur = 25'($urandom_range(0, 1 << 20));
            endcase
            wr_byte(cur, 8'($urandom_range(0, 255)));
            tick($urandom_range(10, 14));
        end
        end_dl();
        wait_done("random");
        chk("random overflow", 40'(overflow), 40'd0);
        rand_dly = 1'b0;

        // Reset with three words queued: everything is discarded.
        ack_en = 1'b0;
        start_dl();
        for (int i = 0; i < 3; i++) begin
            wr_byte(25'(16 + 2 * i), 8'(8'hC0 + i));
            wr_byte(25'(17 + 2 * i), 8'(8'hD0 + i));
        end
        tick(2);
        chk("queued req", 40'(sdr_req), 40'd1);
        reset_n = 1'b0;
        #1;
        chk("async reset req", 40'(sdr_req), 40'd0);
        chk("async reset head", {sdr_addr, sdr_data}, 40'd0);
        chk("async reset flags", {38'd0, rom_loaded, overflow}, 40'd0);
        exp_q.delete();
        pm_vld = 1'b0;
        tick(2);
        reset_n = 1'b1;
        ack_en = 1'b1;
        tick(2);
        ioctl_wr = 1'b1;
        ioctl_addr = 25'd40;
        ioctl_dout = 8'h5A;
        tick(1);
        ioctl_addr = 25'd41;
        tick(1);
        ioctl_wr = 1'b0;
        tick(20);
        chk("post reset req", 40'(sdr_req), 40'd0);
        chk("post reset loaded", 40'(rom_loaded), 40'd0);
        rom_download = 1'b0;
        tick(5);
        chk("idle not loaded", 40'(rom_loaded), 40'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
